mio_switch_port: RTL and testbench

//  Memory-mapped responder for switch input on the MIO bus; CPU is the initiator.

---
 rtl/mio_switch_port.sv | 135 +++++++++++++
 tb/tb_mio_switch_port.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mio_switch_port.sv
// mio_switch_port: MIO bus responder for 16 debounced switches.
// Provides DATA (debounced state), EDGE (sticky change flags, W1C),
// MASK (interrupt enables) and CNT (commit-cycle counter).
// Build option: define MIO_SWPORT_IRQ_EN to include MASK and the irq output;
// without it MASK reads 0 and irq is tied low.
module mio_switch_port #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sw_i,
  input  logic        sel,
  input  logic        mem_w,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned NSW   = 16;
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_EDGE = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_CNT  = 2'd3;

  logic [15:0]      s1_q, s2_q;
  logic [15:0]      stable_q, stable_d;
  logic [CNT_W-1:0] db_cnt_q [NSW];
  logic [CNT_W-1:0] db_cnt_d [NSW];
  logic [15:0]      commit_c;
  logic [15:0]      edge_q, edge_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             wr_c;
  logic             unused_c;

  assign wr_c     = sel & mem_w;
  assign unused_c = ^wdata[31:16];

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
    end
  end

  // Per-bit mismatch counters; a bit commits on its DB_CYCLES-th consecutive mismatch.
  always_comb begin
    commit_c = '0;
    for (int i = 0; i < int'(NSW); i++) begin
      db_cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          commit_c[i] = 1'b1;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
    stable_d = stable_q ^ commit_c;
  end

  // Debounce counters and debounced state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NSW); i++) db_cnt_q[i] <= '0;
      stable_q <= '0;
    end else begin
      for (int i = 0; i < int'(NSW); i++) db_cnt_q[i] <= db_cnt_d[i];
      stable_q <= stable_d;
    end
  end

  // EDGE: new commits win over a same-cycle W1C; CNT: a write wins over an increment.
  always_comb begin
    edge_d = edge_q;
    cnt_d  = cnt_q;
    if (wr_c && addr == A_EDGE) edge_d = edge_q & ~wdata[15:0];
    edge_d = edge_d | commit_c;
    if (|commit_c) cnt_d = cnt_q + 16'd1;
    if (wr_c && addr == A_CNT) cnt_d = '0;
  end

  // EDGE and CNT registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q <= '0;
      cnt_q  <= '0;
    end else begin
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef MIO_SWPORT_IRQ_EN
  logic [15:0] mask_q;
  logic        irq_q;

  // Interrupt mask register and registered level interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_c && addr == A_MASK) mask_q <= wdata[15:0];
      irq_q <= |(edge_q & mask_q);
    end
  end

  assign irq = irq_q;
`else
  logic [15:0] mask_q;
  assign mask_q = '0;
  assign irq    = 1'b0;
`endif

  // Combinational read mux; unused upper bits read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      A_DATA:  rdata = {16'd0, stable_q};
      A_EDGE:  rdata = {16'd0, edge_q};
      A_MASK:  rdata = {16'd0, mask_q};
      A_CNT:   rdata = {16'd0, cnt_q};
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mio_switch_port.sv
// Testbench for mio_switch_port (DB_CYCLES=4): random switch activity, glitches,
// bus writes and mid-run resets checked against a history-window reference model.
module tb_mio_switch_port;

  localparam int unsigned DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_i;
  logic        sel;
  logic        mem_w;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  mio_switch_port #(.DB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_i  (sw_i),
    .sel   (sel),
    .mem_w (mem_w),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  // Reference model state.
  logic [15:0] m_data, m_edge, m_mask, m_cnt;
  logic        m_irq;
  logic [15:0] samp [$];
  int          e0;
  int          lastc [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_edge = '0; m_mask = '0; m_cnt = '0; m_irq = 1'b0;
  endtask

  // Called at reset release: the next edge is the first one counted.
  task automatic model_release();
    e0 = samp.size();
    for (int b = 0; b < 16; b++) lastc[b] = e0 - 1;
  endtask

  // Value the debouncer compares at edge k: input sampled two edges earlier.
  function automatic logic [15:0] syn(input int k);
    if (k - 2 >= e0) return samp[k-2];
    return 16'h0000;
  endfunction

  // A bit commits at edge t when the last DB synchronised samples, all taken
  // after the previous commit (or reset), disagree with the debounced value.
  task automatic model_edge();
    int          t;
    int          lo;
    bit          ok;
    logic [15:0] commit;
    logic [15:0] s;
    bit          wr;
    t      = samp.size();
    commit = '0;
    for (int b = 0; b < 16; b++) begin
      lo = t - int'(DB) + 1;
      if (lo > lastc[b]) begin
        ok = 1'b1;
        for (int k = lo; k <= t; k++) begin
          s = syn(k);
          if (s[b] == m_data[b]) ok = 1'b0;
        end
        if (ok) begin
          commit[b] = 1'b1;
          lastc[b]  = t;
        end
      end
    end
    wr = sel && mem_w;
`ifdef MIO_SWPORT_IRQ_EN
    m_irq = |(m_edge & m_mask);
    if (wr && addr == 2'd2) m_mask = wdata[15:0];
`endif
    if (wr && addr == 2'd1) m_edge = m_edge & ~wdata[15:0];
    m_edge = m_edge | commit;
    if (wr && addr == 2'd3) m_cnt = '0;
    else if (commit != 16'h0) m_cnt = m_cnt + 16'd1;
    m_data = m_data ^ commit;
    samp.push_back(sw_i);
  endtask

  task automatic check_regs(input string tag);
    logic [15:0] exp [4];
    exp[0] = m_data; exp[1] = m_edge; exp[2] = m_mask; exp[3] = m_cnt;
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("%s_reg%0d", tag, a), rdata, {16'd0, exp[a]});
    end
  endtask

  int gbit;
  int gtime;

  initial begin
    rst = 1'b1; sw_i = '0; sel = 1'b0; mem_w = 1'b0; addr = '0; wdata = '0;
    gbit = 0; gtime = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_regs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_release();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // Occasional asynchronous reset, often while a debounce is in flight.
      if (cyc % 733 == 400) begin
        sw_i = sw_i ^ 16'h00F0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_regs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        model_release();
      end
      // Switch activity: occasional clean flips plus short glitches.
      if (gtime > 0) begin
        gtime--;
        if (gtime == 0) sw_i[gbit] = ~sw_i[gbit];
      end else if ($urandom_range(0, 19) == 0) begin
        gbit  = int'($urandom_range(0, 15));
        gtime = int'($urandom_range(1, DB));
        sw_i[gbit] = ~sw_i[gbit];
      end
      if ($urandom_range(0, 11) == 0)
        sw_i = sw_i ^ (16'(1) << $urandom_range(0, 15));
      // Bus traffic, including select/strobe combinations that must not write.
      sel   = ($urandom_range(0, 5) == 0);
      mem_w = ($urandom_range(0, 3) != 0);
      addr  = 2'($urandom_range(0, 3));
      wdata = $urandom;
      if ($urandom_range(0, 1) == 0) wdata[15:0] = 16'h0000;
      @(posedge clk);
      model_edge();
      #1;
      check_regs("run");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
